// File: rtl/fifo_vc_multi_pkg.sv
// Shared types and sizing helpers for the multi-VC FIFO.
package fifo_vc_multi_pkg;

    typedef enum logic {
        PAUSE_OFF = 1'b0,
        PAUSE_ON  = 1'b1
    } pause_state_e;

    function automatic int vc_width(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/vc_queue_ctrl.sv
// Bookkeeping for one virtual channel: pointers, occupancy, flags, pause and sticky error.
module vc_queue_ctrl
    import fifo_vc_multi_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic [ADDR_W:0]   af_thresh,
    input  logic [ADDR_W:0]   ae_thresh,
    input  logic              err_clr,
    output logic              push_ok,
    output logic              pop_ok,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              pause,
    output logic              error
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(depth_of(ADDR_W));
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W:0] count;
    logic [ADDR_W:0] count_next;
    pause_state_e    state;
    pause_state_e    state_next;
    logic            error_next;

    always_comb begin
        empty        = (count == '0);
        full         = (count == DEPTH);
        almost_full  = (count >= af_thresh);
        almost_empty = !empty && (count <= ae_thresh);
        push_ok      = push_req && !full;
        pop_ok       = pop_req && !empty;

        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_next = count - CNT_ONE;
        end

        // Set is tested first so overlapping thresholds resolve to paused.
        state_next = state;
        if (count_next >= af_thresh) begin
            state_next = PAUSE_ON;
        end else if (count_next <= ae_thresh) begin
            state_next = PAUSE_OFF;
        end

        error_next = error;
        if ((push_req && full) || (pop_req && empty)) begin
            error_next = 1'b1;
        end else if (err_clr) begin
            error_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= PAUSE_OFF;
            error  <= 1'b0;
        end else begin
            count  <= count_next;
            state  <= state_next;
            error  <= error_next;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign pause = (state == PAUSE_ON);

endmodule

// File: rtl/fifo_vc_multi.sv
// Multi-virtual-channel FIFO: flat shared storage, per-VC control, registered read port.
module fifo_vc_multi
    import fifo_vc_multi_pkg::*;
#(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_W    = 2,
    parameter int NUM_VC    = 2,
    localparam int VC_W     = vc_width(NUM_VC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [VC_W-1:0]      push_vc,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 pop,
    input  logic [VC_W-1:0]      pop_vc,
    input  logic [ADDR_W:0]      af_thresh,
    input  logic [ADDR_W:0]      ae_thresh,
    input  logic [NUM_VC-1:0]    err_clr,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 data_valid,
    output logic [NUM_VC-1:0]    empty,
    output logic [NUM_VC-1:0]    full,
    output logic [NUM_VC-1:0]    almost_full,
    output logic [NUM_VC-1:0]    almost_empty,
    output logic [NUM_VC-1:0]    pause,
    output logic [NUM_VC-1:0]    error
);

    localparam int MEM_W = VC_W + ADDR_W;

    logic [NUM_VC-1:0]    push_hit;
    logic [NUM_VC-1:0]    pop_hit;
    logic [NUM_VC-1:0]    push_ok;
    logic [NUM_VC-1:0]    pop_ok;
    logic [ADDR_W-1:0]    wr_ptr [NUM_VC];
    logic [ADDR_W-1:0]    rd_ptr [NUM_VC];
    logic                 wr_en;
    logic                 rd_en;
    logic [MEM_W-1:0]     wr_addr;
    logic [MEM_W-1:0]     rd_addr;
    logic [DATA_SIZE-1:0] mem [1 << MEM_W];

    // Out-of-range VC indices match no channel, so such requests vanish silently.
    always_comb begin
        push_hit = '0;
        pop_hit  = '0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_addr  = '0;
        rd_addr  = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            push_hit[v] = push && (push_vc == VC_W'(v));
            pop_hit[v]  = pop && (pop_vc == VC_W'(v));
            if (push_ok[v]) begin
                wr_en   = !reset;
                wr_addr = {VC_W'(v), wr_ptr[v]};
            end
            if (pop_ok[v]) begin
                rd_en   = !reset;
                rd_addr = {VC_W'(v), rd_ptr[v]};
            end
        end
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        vc_queue_ctrl #(
            .ADDR_W(ADDR_W)
        ) u_ctrl (
            .clk         (clk),
            .reset       (reset),
            .push_req    (push_hit[g]),
            .pop_req     (pop_hit[g]),
            .af_thresh   (af_thresh),
            .ae_thresh   (ae_thresh),
            .err_clr     (err_clr[g]),
            .push_ok     (push_ok[g]),
            .pop_ok      (pop_ok[g]),
            .wr_ptr      (wr_ptr[g]),
            .rd_ptr      (rd_ptr[g]),
            .empty       (empty[g]),
            .full        (full[g]),
            .almost_full (almost_full[g]),
            .almost_empty(almost_empty[g]),
            .pause       (pause[g]),
            .error       (error[g])
        );
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_en;
            if (rd_en) begin
                data_out <= mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_fifo_vc_multi.sv
// Scoreboard bench for fifo_vc_multi: queue-based reference model, directed then random traffic.
module tb_fifo_vc_multi;

    localparam int DS    = 6;
    localparam int AW    = 2;
    localparam int NV    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic [0:0]    push_vc = '0;
    logic [DS-1:0] data_in = '0;
    logic          pop = 1'b0;
    logic [0:0]    pop_vc = '0;
    logic [AW:0]   af_thresh = 3'd4;
    logic [AW:0]   ae_thresh = 3'd0;
    logic [NV-1:0] err_clr = '0;
    logic [DS-1:0] data_out;
    logic          data_valid;
    logic [NV-1:0] empty, full, almost_full, almost_empty, pause, error;

    fifo_vc_multi #(
        .DATA_SIZE(DS),
        .ADDR_W   (AW),
        .NUM_VC   (NV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_vc     (push_vc),
        .data_in     (data_in),
        .pop         (pop),
        .pop_vc      (pop_vc),
        .af_thresh   (af_thresh),
        .ae_thresh   (ae_thresh),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .pause       (pause),
        .error       (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            valid;
        logic [DS-1:0] dout;
        logic [NV-1:0] empty, full, af, ae, pause, error;
    } exp_t;

    exp_t          sb[$];
    logic [DS-1:0] mq [NV][$];
    bit            merr [NV];
    bit            mpause [NV];
    logic [DS-1:0] mdout;
    logic [AW:0]   cur_af = 3'd4;
    logic [AW:0]   cur_ae = 3'd0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model derives the outcome from occupancy rules only.
    task automatic step(input bit p, input int pv, input logic [DS-1:0] d,
                        input bit o, input int ov, input logic [NV-1:0] clr, input bit rst);
        exp_t e;
        bit   fullp [NV];
        bit   seterr [NV];
        int   c;
        @(negedge clk);
        reset     = rst;
        push      = p;
        push_vc   = 1'(pv);
        data_in   = d;
        pop       = o;
        pop_vc    = 1'(ov);
        err_clr   = clr;
        af_thresh = cur_af;
        ae_thresh = cur_ae;
        e.valid = 1'b0;
        if (rst) begin
            for (int v = 0; v < NV; v++) begin
                mq[v].delete();
                merr[v]   = 1'b0;
                mpause[v] = 1'b0;
            end
            mdout = '0;
        end else begin
            for (int v = 0; v < NV; v++) begin
                fullp[v]  = (mq[v].size() == DEPTH);
                seterr[v] = 1'b0;
            end
            if (o && ov < NV) begin
                if (mq[ov].size() == 0) seterr[ov] = 1'b1;
                else begin
                    mdout   = mq[ov].pop_front();
                    e.valid = 1'b1;
                end
            end
            if (p && pv < NV) begin
                if (fullp[pv]) seterr[pv] = 1'b1;
                else mq[pv].push_back(d);
            end
            for (int v = 0; v < NV; v++) begin
                if (seterr[v]) merr[v] = 1'b1;
                else if (clr[v]) merr[v] = 1'b0;
                c = mq[v].size();
                if (c >= int'(cur_af)) mpause[v] = 1'b1;
                else if (c <= int'(cur_ae)) mpause[v] = 1'b0;
            end
        end
        e.dout = mdout;
        for (int v = 0; v < NV; v++) begin
            c = mq[v].size();
            e.empty[v] = (c == 0);
            e.full[v]  = (c == DEPTH);
            e.af[v]    = (c >= int'(cur_af));
            e.ae[v]    = (c > 0) && (c <= int'(cur_ae));
            e.pause[v] = mpause[v];
            e.error[v] = merr[v];
        end
        sb.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, '0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("data_valid", 32'(data_valid), 32'(e.valid));
                chk("data_out", 32'(data_out), 32'(e.dout));
                chk("empty", 32'(empty), 32'(e.empty));
                chk("full", 32'(full), 32'(e.full));
                chk("almost_full", 32'(almost_full), 32'(e.af));
                chk("almost_empty", 32'(almost_empty), 32'(e.ae));
                chk("pause", 32'(pause), 32'(e.pause));
                chk("error", 32'(error), 32'(e.error));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        step(0, 0, '0, 0, 0, '0, 1);
        step(0, 0, '0, 0, 0, '0, 1);

        // Fill VC0, overflow, then drain in order.
        cur_af = 3'd4; cur_ae = 3'd0;
        for (int i = 0; i < 4; i++) step(1, 0, DS'(8'h11 + i), 0, 0, '0, 0);
        step(1, 0, 6'h2a, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 0, '0, 0);
        idle();

        // Pause hysteresis on VC1.
        step(0, 0, '0, 0, 0, 2'b11, 0);
        cur_af = 3'd3; cur_ae = 3'd1;
        for (int i = 0; i < 3; i++) step(1, 1, DS'(8'h21 + i), 0, 0, '0, 0);
        step(0, 0, '0, 1, 1, '0, 0);
        step(0, 0, '0, 1, 1, '0, 0);
        step(0, 0, '0, 1, 1, '0, 0);

        // Concurrent push/pop, same and different VC.
        step(1, 0, 6'h31, 0, 0, '0, 0);
        step(1, 0, 6'h32, 0, 0, '0, 0);
        step(1, 0, 6'h33, 1, 0, '0, 0);
        step(1, 0, 6'h34, 1, 1, '0, 0);
        idle();

        // Error clear with no fault, then clear racing an overflow.
        step(0, 0, '0, 0, 0, 2'b01, 0);
        step(0, 0, '0, 0, 0, 2'b10, 0);
        step(1, 0, 6'h35, 0, 0, '0, 0);
        step(1, 0, 6'h36, 1, 1, 2'b01, 0);
        step(1, 0, 6'h37, 0, 0, 2'b01, 0);
        step(0, 0, '0, 0, 0, 2'b11, 0);

        // Reset in the middle of traffic.
        step(1, 1, 6'h3a, 1, 0, '0, 0);
        step(1, 1, 6'h3b, 1, 0, '0, 1);
        idle();

        // Pointer wrap on VC1 while VC0 holds data.
        step(1, 0, 6'h05, 0, 0, '0, 0);
        step(1, 1, 6'h00, 0, 0, '0, 0);
        for (int i = 1; i <= 10; i++) step(1, 1, DS'(i), 1, 1, '0, 0);
        step(0, 0, '0, 1, 1, '0, 0);
        step(0, 0, '0, 1, 0, '0, 0);
        idle();

        // Random traffic, thresholds reshuffled periodically (including 0).
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                cur_af = 3'($urandom_range(0, 4));
                cur_ae = 3'($urandom_range(0, 4));
            end
            step($urandom_range(0, 9) < 6, int'($urandom_range(0, 1)), DS'($urandom),
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0) ? NV'($urandom) : '0,
                 $urandom_range(0, 149) == 0);
        end
        idle();

        begin : drain
            for (int i = 0; i < 10; i++) begin
                if (sb.size() == 0) break;
                @(posedge clk);
                #2;
            end
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
